// File: rtl/param_data_array.sv
// param_data_array: multi-way cache data store with a registered read port, per-line dirty bits
// and a beat-serial line-fill engine. Define DATA_ARRAY_PARITY_EN for per-byte even parity.
module param_data_array #(
  parameter int S_INDEX    = 3,
  parameter int WAYS       = 2,
  parameter int LINE_BYTES = 32,
  parameter int BEAT_BYTES = 8,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic [S_INDEX-1:0]        rindex,
  input  logic [WW-1:0]             rway,
  output logic [8*LINE_BYTES-1:0]   rdata,
  output logic                      rdirty,
  output logic                      rvalid,
  input  logic                      wr_en,
  output logic                      wr_ready,
  input  logic [S_INDEX-1:0]        windex,
  input  logic [WW-1:0]             wway,
  input  logic [LINE_BYTES-1:0]     wmask,
  input  logic [8*LINE_BYTES-1:0]   wdata,
  input  logic                      fill_start,
  input  logic [S_INDEX-1:0]        fill_index,
  input  logic [WW-1:0]             fill_way,
  input  logic                      fill_beat_valid,
  input  logic [8*BEAT_BYTES-1:0]   fill_beat_data,
`ifdef DATA_ARRAY_PARITY_EN
  input  logic                      perr_inject,
  output logic                      parity_err,
`endif
  output logic                      fill_busy,
  output logic                      fill_done
);
  localparam int SETS  = 2 ** S_INDEX;
  localparam int NL    = SETS * WAYS;
  localparam int WB    = $clog2(WAYS);
  localparam int LW    = S_INDEX + WB;
  localparam int LBITS = 8 * LINE_BYTES;
  localparam int BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int BBITS = 8 * BEAT_BYTES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  function automatic logic [LW-1:0] line_addr(input logic [S_INDEX-1:0] idx, input logic [WW-1:0] way);
    logic [LW-1:0] a;
    a = LW'(idx) << WB;
    a = a | LW'(way & WW'(WAYS - 1));
    return a;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [BW-1:0]        r_beat, w_beat_nxt;
  logic [S_INDEX-1:0]   r_fill_index;
  logic [WW-1:0]        r_fill_way;
  logic                 r_fill_done;
  logic                 w_beat_we, w_fill_last, w_fill_go, w_wr_acc;

  logic [LBITS-1:0]     r_mem [NL];
  logic [NL-1:0]        r_dirty;
  logic [LW-1:0]        w_waddr, w_faddr, w_raddr;
  logic [LBITS-1:0]     w_wr_line, w_fill_line, w_rd_line;
  logic [LINE_BYTES-1:0] w_beat_mask, w_fwd_mask;
  logic                 w_fwd_wr, w_fwd_fill, w_rd_dirty;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_beat_we   = 1'b0;
    w_fill_last = 1'b0;
    w_fill_go   = 1'b0;
    case (r_state)
      IDLE: if (fill_start) begin
        w_fill_go   = 1'b1;
        w_beat_nxt  = '0;
        w_state_nxt = FILL;
      end
      FILL: if (fill_beat_valid) begin
        w_beat_we = 1'b1;
        if (r_beat == BW'(BEATS - 1)) begin
          w_fill_last = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = IDLE;
        end else begin
          w_beat_nxt = r_beat + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_fill_index <= '0;
      r_fill_way   <= '0;
      r_fill_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_fill_done <= w_fill_last;
      if (w_fill_go) begin
        r_fill_index <= fill_index;
        r_fill_way   <= fill_way;
      end
    end
  end

  assign wr_ready  = (r_state == IDLE);
  assign fill_busy = (r_state == FILL);
  assign fill_done = r_fill_done;
  assign w_wr_acc  = wr_en && wr_ready;
  assign w_waddr   = line_addr(windex, wway);
  assign w_faddr   = line_addr(r_fill_index, r_fill_way);
  assign w_raddr   = line_addr(rindex, rway);

  // Writes happen only in IDLE and beats only in FILL, so the two never target a line together.
  always_comb begin
    w_wr_line = r_mem[w_waddr];
    for (int i = 0; i < LINE_BYTES; i++)
      if (wmask[i]) w_wr_line[8*i +: 8] = wdata[8*i +: 8];
    w_fill_line = r_mem[w_faddr];
    w_fill_line[r_beat*BBITS +: BBITS] = fill_beat_data;
    w_beat_mask = '0;
    w_beat_mask[r_beat*BEAT_BYTES +: BEAT_BYTES] = '1;
  end

  always_comb begin
    w_fwd_wr   = w_wr_acc && (w_raddr == w_waddr);
    w_fwd_fill = w_beat_we && (w_raddr == w_faddr);
    w_rd_line  = r_mem[w_raddr];
    w_rd_dirty = r_dirty[w_raddr];
    w_fwd_mask = '0;
    if (w_fwd_wr) begin
      w_rd_line  = w_wr_line;
      w_rd_dirty = 1'b1;
      w_fwd_mask = wmask;
    end else if (w_fwd_fill) begin
      w_rd_line  = w_fill_line;
      w_rd_dirty = 1'b0;
      w_fwd_mask = w_beat_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) r_mem[i] <= '0;
      r_dirty <= '0;
    end else begin
      if (w_wr_acc) begin
        r_mem[w_waddr]   <= w_wr_line;
        r_dirty[w_waddr] <= 1'b1;
      end
      if (w_beat_we) begin
        r_mem[w_faddr] <= w_fill_line;
        if (w_fill_last) r_dirty[w_faddr] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rdirty <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata  <= w_rd_line;
        rdirty <= w_rd_dirty;
      end
    end
  end

`ifdef DATA_ARRAY_PARITY_EN
  logic [LINE_BYTES-1:0] r_par [NL];
  logic [LINE_BYTES-1:0] w_wr_par, w_fill_par, w_rd_par;
  logic                  w_perr;

  // Stored bit makes each byte plus parity even; forwarded bytes are trusted as freshly computed.
  always_comb begin
    w_wr_par   = r_par[w_waddr];
    w_fill_par = r_par[w_faddr];
    w_rd_par   = r_par[w_raddr];
    w_perr     = 1'b0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (wmask[i])       w_wr_par[i]   = (^wdata[8*i +: 8]) ^ perr_inject;
      if (w_beat_mask[i]) w_fill_par[i] = ^w_fill_line[8*i +: 8];
      if (!w_fwd_mask[i] && ((^w_rd_line[8*i +: 8]) != w_rd_par[i])) w_perr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) r_par[i] <= '0;
      parity_err <= 1'b0;
    end else begin
      if (w_wr_acc)  r_par[w_waddr] <= w_wr_par;
      if (w_beat_we) r_par[w_faddr] <= w_fill_par;
      if (rd_en)     parity_err <= w_perr;
    end
  end
`endif

endmodule

// File: tb/tb_param_data_array.sv
// tb_param_data_array: scoreboard bench for param_data_array with a byte-array reference model.
// Parity checks are compiled in when DATA_ARRAY_PARITY_EN is defined.
module tb_param_data_array;
  localparam int LB = 32, BB = 8, BEATS = LB / BB, WAYS = 2, NL = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic rd_en = 0, wr_en = 0, fill_start = 0, fill_beat_valid = 0;
  logic [2:0] rindex = 0, windex = 0, fill_index = 0;
  logic [0:0] rway = 0, wway = 0, fill_way = 0;
  logic [LB-1:0] wmask = 0;
  logic [8*LB-1:0] wdata = 0, rdata;
  logic [8*BB-1:0] fill_beat_data = 0;
  logic rdirty, rvalid, wr_ready, fill_busy, fill_done;
`ifdef DATA_ARRAY_PARITY_EN
  logic perr_inject = 0, parity_err;
`endif

  param_data_array dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rindex(rindex), .rway(rway), .rdata(rdata),
    .rdirty(rdirty), .rvalid(rvalid), .wr_en(wr_en), .wr_ready(wr_ready), .windex(windex),
    .wway(wway), .wmask(wmask), .wdata(wdata), .fill_start(fill_start), .fill_index(fill_index),
    .fill_way(fill_way), .fill_beat_valid(fill_beat_valid), .fill_beat_data(fill_beat_data),
`ifdef DATA_ARRAY_PARITY_EN
    .perr_inject(perr_inject), .parity_err(parity_err),
`endif
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              due;
    logic [8*LB-1:0] data;
    bit              dirty;
    bit              perr;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;

  // Reference model: byte image of every line, dirty flags, bytes with corrupted parity, fill progress.
  logic [7:0] m_mem [NL][LB];
  bit m_dirty [NL];
  bit m_bad [NL][LB];
  bit m_busy, m_done;
  int m_fline, m_k;

  task automatic chk(input string name, input logic [8*LB-1:0] act, input logic [8*LB-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, req);
    end
  endtask

  function automatic void model_clear();
    for (int l = 0; l < NL; l++) begin
      m_dirty[l] = 0;
      for (int b = 0; b < LB; b++) begin m_mem[l][b] = 8'h00; m_bad[l][b] = 0; end
    end
    m_busy = 0; m_done = 0; m_fline = 0; m_k = 0;
  endfunction

  function automatic logic [8*LB-1:0] rand_line();
    logic [8*LB-1:0] v;
    for (int i = 0; i < LB / 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_idle();
    rd_en = 0; wr_en = 0; fill_start = 0; fill_beat_valid = 0; wmask = '0;
`ifdef DATA_ARRAY_PARITY_EN
    perr_inject = 0;
`endif
  endtask

  // One clock: check status outputs, apply the cycle's inputs to the model, queue any read result.
  task automatic step();
    exp_t e;
    bit fwd [LB];
    bit acc, beat, new_done, pi;
    int wl, rl, fl, b;
    chk("wr_ready", 256'(wr_ready), 256'(!m_busy));
    chk("fill_busy", 256'(fill_busy), 256'(m_busy));
    chk("fill_done", 256'(fill_done), 256'(m_done));
    pi = 0;
`ifdef DATA_ARRAY_PARITY_EN
    pi = perr_inject;
`endif
    for (int i = 0; i < LB; i++) fwd[i] = 0;
    wl = int'(windex) * WAYS + int'(wway);
    rl = int'(rindex) * WAYS + int'(rway);
    fl = m_fline;
    acc = wr_en && !m_busy;
    beat = m_busy && fill_beat_valid;
    new_done = 0;
    if (acc) begin
      for (int i = 0; i < LB; i++)
        if (wmask[i]) begin
          m_mem[wl][i] = wdata[8*i +: 8];
          m_bad[wl][i] = pi;
          if (wl == rl) fwd[i] = 1;
        end
      m_dirty[wl] = 1;
    end
    if (beat) begin
      for (int j = 0; j < BB; j++) begin
        b = m_k * BB + j;
        m_mem[fl][b] = fill_beat_data[8*j +: 8];
        m_bad[fl][b] = 0;
        if (fl == rl) fwd[b] = 1;
      end
      m_k++;
      if (m_k == BEATS) begin
        m_dirty[fl] = 0; m_busy = 0; m_k = 0; new_done = 1;
      end
    end else if (!m_busy && fill_start) begin
      m_busy = 1; m_fline = int'(fill_index) * WAYS + int'(fill_way); m_k = 0;
    end
    if (rd_en) begin
      e.due = cyc + 1;
      for (int i = 0; i < LB; i++) e.data[8*i +: 8] = m_mem[rl][i];
      e.dirty = (beat && fl == rl) ? 1'b0 : m_dirty[rl];
      e.perr = 0;
      for (int i = 0; i < LB; i++) if (m_bad[rl][i] && !fwd[i]) e.perr = 1;
      q.push_back(e);
    end
    m_done = new_done;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    step();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    q.delete();
  endtask

  task automatic rd(input int idx, input int way);
    rd_en = 1; rindex = 3'(idx); rway = 1'(way);
  endtask

  task automatic wr(input int idx, input int way, input logic [LB-1:0] m, input logic [8*LB-1:0] d);
    wr_en = 1; windex = 3'(idx); wway = 1'(way); wmask = m; wdata = d;
  endtask

  // Monitor: every rvalid must match the oldest queued expectation due in this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          total++;
          if (!rvalid) begin
            bad++;
            $display("FAIL rvalid at cycle %0d: got 0 want 1", cyc);
          end else begin
            chk("rdata", rdata, e.data);
            chk("rdirty", 256'(rdirty), 256'(e.dirty));
`ifdef DATA_ARRAY_PARITY_EN
            chk("parity_err", 256'(parity_err), 256'(e.perr));
`endif
          end
        end else begin
          chk("rvalid_idle", 256'(rvalid), 256'(0));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_rvalid", 256'(rvalid), 256'(0));
    chk("reset_rdata", rdata, 256'(0));
    chk("reset_rdirty", 256'(rdirty), 256'(0));
    chk("reset_fill_busy", 256'(fill_busy), 256'(0));
    chk("reset_fill_done", 256'(fill_done), 256'(0));
    chk("reset_wr_ready", 256'(wr_ready), 256'(1));

    set_idle(); rd(5, 1); step();
    set_idle(); step();

    set_idle(); wr(2, 0, 32'h0000_000F, {{28{8'hFF}}, 32'hDEAD_BEEF}); step();
    set_idle(); step();
    set_idle(); rd(2, 0); step();

    set_idle(); wr(3, 0, '1, rand_line()); step();
    set_idle(); wr(3, 1, 32'h1, {{31{8'h00}}, 8'hA5}); rd(3, 1); step();
    set_idle(); rd(3, 0); step();

    set_idle(); wr(4, 1, '1, rand_line()); step();
    set_idle(); fill_start = 1; fill_index = 3'd4; fill_way = 1'b1; step();
    set_idle(); fill_beat_valid = 1; fill_beat_data = {8{8'h11}}; rd(4, 1); step();
    set_idle(); wr(4, 1, '1, rand_line()); fill_start = 1; fill_index = 3'd0; step();
    set_idle(); rd(4, 1); step();
    set_idle(); fill_beat_valid = 1; fill_beat_data = {8{8'h22}}; step();
    set_idle(); fill_beat_valid = 1; fill_beat_data = {8{8'h33}}; step();
    set_idle(); fill_beat_valid = 1; fill_beat_data = {8{8'h44}}; rd(4, 1); step();
    set_idle(); fill_beat_valid = 1; fill_beat_data = {8{8'h55}}; step();
    set_idle(); rd(4, 1); step();
    set_idle(); step();

    set_idle(); fill_start = 1; fill_index = 3'd6; fill_way = 1'b0; step();
    set_idle(); fill_beat_valid = 1; fill_beat_data = {8{8'h77}}; step();
    set_idle(); fill_beat_valid = 1; fill_beat_data = {8{8'h88}}; step();
    do_reset();
    set_idle(); rd(6, 0); step();
    set_idle(); fill_start = 1; fill_index = 3'd6; fill_way = 1'b0; step();
    for (int k = 0; k < BEATS; k++) begin
      set_idle(); fill_beat_valid = 1; fill_beat_data = {$urandom, $urandom}; step();
    end
    set_idle(); rd(6, 0); step();
    set_idle(); step();

`ifdef DATA_ARRAY_PARITY_EN
    set_idle(); wr(1, 0, 32'hF, rand_line()); perr_inject = 1; step();
    set_idle(); rd(1, 0); step();
    set_idle(); wr(1, 0, 32'hF, rand_line()); step();
    set_idle(); rd(1, 0); step();
`endif

    for (int n = 0; n < 3000; n++) begin
      set_idle();
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 1) == 1) rd($urandom_range(0, 7), $urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 7), $urandom_range(0, 1), $urandom, rand_line());
        fill_start = ($urandom_range(0, 7) == 0);
        fill_index = 3'($urandom);
        fill_way = 1'($urandom);
        fill_beat_valid = ($urandom_range(0, 1) == 1);
        fill_beat_data = {$urandom, $urandom};
`ifdef DATA_ARRAY_PARITY_EN
        perr_inject = ($urandom_range(0, 7) == 0);
`endif
        step();
      end
    end
    set_idle(); step();
    step();
    chk("queue_drained", 256'(q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
